// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - request FIFO feeding an external 8-bit ALU with a registered, backpressured result
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_a,
    input  logic [7:0]    in_b,
    input  logic [2:0]    in_sel,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [2:0]    alu_sel,
    input  logic [7:0]    alu_out,
    input  logic          alu_cout,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [7:0]    res_data,
    output logic          res_cout,
    output logic          res_zero,
    output logic          res_dbz,
    output logic [AW:0]   level
);

    localparam logic RES_EMPTY = 1'b0;
    localparam logic RES_FULL  = 1'b1;
    localparam logic [AW:0] LEVEL_MAX = (AW+1)'(DEPTH);

    logic [7:0]    q_a   [0:DEPTH-1];
    logic [7:0]    q_b   [0:DEPTH-1];
    logic [2:0]    q_sel [0:DEPTH-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          res_state;
    logic          empty;
    logic          push;
    logic          can_issue;

    assign empty     = (level == '0);
    assign in_ready  = (level != LEVEL_MAX);
    assign push      = in_valid && in_ready;
    assign res_valid = (res_state == RES_FULL);
    assign can_issue = !empty && (!res_valid || res_ready);

    // Idle ALU inputs are forced to zero so the ALU sees a quiet operand set.
    assign alu_a   = empty ? 8'd0 : q_a[rd_ptr];
    assign alu_b   = empty ? 8'd0 : q_b[rd_ptr];
    assign alu_sel = empty ? 3'd0 : q_sel[rd_ptr];

    // Storage is deliberately not reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q_a[wr_ptr]   <= in_a;
            q_b[wr_ptr]   <= in_b;
            q_sel[wr_ptr] <= in_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (can_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, can_issue})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_state <= RES_EMPTY;
            res_data  <= 8'd0;
            res_cout  <= 1'b0;
            res_zero  <= 1'b0;
            res_dbz   <= 1'b0;
        end else begin
            case (res_state)
                RES_EMPTY: begin
                    if (can_issue) begin
                        res_state <= RES_FULL;
                    end
                end
                RES_FULL: begin
                    if (res_ready && !can_issue) begin
                        res_state <= RES_EMPTY;
                    end
                end
                default: res_state <= RES_EMPTY;
            endcase
            if (can_issue) begin
                res_data <= alu_out;
                res_cout <= alu_cout;
                res_zero <= (alu_out == 8'd0);
                res_dbz  <= (alu_sel == 3'b011) && (alu_b == 8'd0);
            end
        end
    end

endmodule
